// File: rtl/temporal_bundler.sv
// temporal_bundler: majority-bundles WINDOW consecutive accepted hypervectors
// into one registered output hypervector, with a valid/ready handshake on
// both sides.
// Optional build macro BUNDLE_TIEBREAK_LAST_EN: an even-WINDOW tie on a bit
// resolves to that bit of the last accepted input instead of 0.
`ifndef HV_DIMENSION
`define HV_DIMENSION 16
`endif

module temporal_bundler #(
  parameter int WINDOW = 5
) (
  input  logic                        Clk_CI,
  input  logic                        Reset_RI,
  input  logic                        ValidIn_SI,
  output logic                        ReadyOut_SO,
  input  logic [0:`HV_DIMENSION-1]    HypervectorIn_DI,
  output logic                        ValidOut_SO,
  input  logic                        ReadyIn_SI,
  output logic [0:`HV_DIMENSION-1]    HypervectorOut_DO
);

  localparam int D  = `HV_DIMENSION;
  // Counters must reach WINDOW itself, so WINDOW+1 distinct values.
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] HALF_C = CW'(WINDOW / 2);
  localparam logic [CW-1:0] LAST_C = CW'(WINDOW - 1);
  localparam bit WINDOW_EVEN = (WINDOW % 2) == 0;

  typedef enum logic {ST_ACCUM, ST_OUTPUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q [D];
  logic [CW-1:0]   cnt_d [D];
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [0:D-1]    hv_q, hv_d;

  // Per-bit updated count and the majority decision it implies.
  logic [CW-1:0]   sum_w [D];
  logic [0:D-1]    maj_w;

  for (genvar gi = 0; gi < D; gi++) begin : gen_bit
    logic gt_w;
    logic tie_w;
    assign sum_w[gi] = cnt_q[gi] + CW'(HypervectorIn_DI[gi]);
    assign gt_w      = sum_w[gi] > HALF_C;
    assign tie_w     = WINDOW_EVEN && (sum_w[gi] == HALF_C);
`ifdef BUNDLE_TIEBREAK_LAST_EN
    // The last input decides a tie, so the newest sample breaks the draw.
    assign maj_w[gi] = gt_w | (tie_w & HypervectorIn_DI[gi]);
`else
    // Ties fall to 0; tie_w is kept so both builds share one datapath.
    assign maj_w[gi] = gt_w | (tie_w & 1'b0);
`endif
  end

  // Next-state: accumulate in ACCUM, hold in OUTPUT until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_cnt_d = in_cnt_q;
    hv_d     = hv_q;
    case (state_q)
      ST_ACCUM: begin
        if (ValidIn_SI) begin
          for (int n = 0; n < D; n++) begin
            cnt_d[n] = sum_w[n];
          end
          if (in_cnt_q == LAST_C) begin
            hv_d     = maj_w;
            in_cnt_d = '0;
            state_d  = ST_OUTPUT;
          end else begin
            in_cnt_d = in_cnt_q + CW'(1);
          end
        end
      end
      ST_OUTPUT: begin
        // Inputs are ignored here; only the downstream handshake moves us on.
        if (ReadyIn_SI) begin
          for (int n = 0; n < D; n++) begin
            cnt_d[n] = '0;
          end
          in_cnt_d = '0;
          state_d  = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State registers; reset discards any partial window and clears the output.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q  <= ST_ACCUM;
      in_cnt_q <= '0;
      hv_q     <= '0;
      for (int n = 0; n < D; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      hv_q     <= hv_d;
      for (int n = 0; n < D; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign ReadyOut_SO       = (state_q == ST_ACCUM);
  assign ValidOut_SO       = (state_q == ST_OUTPUT);
  assign HypervectorOut_DO = hv_q;

endmodule

// File: tb/tb_temporal_bundler.sv
// Bench for temporal_bundler: three instances (WINDOW = 3, 4, 5) driven by
// directed vectors, checked every cycle against a window-level model plus
// literal expectations at key points.
`ifndef HV_DIMENSION
`define HV_DIMENSION 16
`endif

module tb_temporal_bundler;

  localparam int DIM = `HV_DIMENSION;
  localparam logic [0:DIM-1] ONES  = '1;
  localparam logic [0:DIM-1] ZEROS = '0;

  logic             clk;
  logic             rst;
  logic             vin  [3];
  logic             rin  [3];
  logic [0:DIM-1]   din  [3];
  logic             vout [3];
  logic             rout [3];
  logic [0:DIM-1]   hout [3];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    temporal_bundler #(.WINDOW(gi + 3)) u_dut (
      .Clk_CI           (clk),
      .Reset_RI         (rst),
      .ValidIn_SI       (vin[gi]),
      .ReadyOut_SO      (rout[gi]),
      .HypervectorIn_DI (din[gi]),
      .ValidOut_SO      (vout[gi]),
      .ReadyIn_SI       (rin[gi]),
      .HypervectorOut_DO(hout[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             mw [3] = '{3, 4, 5};
  logic [0:DIM-1] macc [3][16];
  int             mcnt [3];
  bit             mvalid [3];
  logic [0:DIM-1] mout [3];
  bit             cmp_en = 0;

  function automatic logic [0:DIM-1] bundle(input int k, input logic [0:DIM-1] last);
    logic [0:DIM-1] r;
    int ones;
    for (int b = 0; b < DIM; b++) begin
      ones = 0;
      for (int i = 0; i < mw[k]; i++) ones += int'(macc[k][i][b]);
      if (ones > mw[k] / 2) r[b] = 1'b1;
      else if ((mw[k] % 2 == 0) && ones == mw[k] / 2) begin
`ifdef BUNDLE_TIEBREAK_LAST_EN
        r[b] = last[b];
`else
        r[b] = 1'b0;
`endif
      end else r[b] = 1'b0;
    end
    return r;
  endfunction

  // Compare at the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial begin
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; mvalid[k] = 0; mout[k] = '0;
    end
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("model_valid[%0d]", k), 64'(vout[k]), 64'(mvalid[k]));
          chk($sformatf("model_ready[%0d]", k), 64'(rout[k]), 64'(!mvalid[k]));
          chk($sformatf("model_hv[%0d]", k), 64'(hout[k]), 64'(mout[k]));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          mcnt[k] = 0; mvalid[k] = 0; mout[k] = '0;
        end else if (mvalid[k]) begin
          if (rin[k]) begin
            mvalid[k] = 0; mcnt[k] = 0;
          end
        end else if (vin[k]) begin
          macc[k][mcnt[k]] = din[k];
          mcnt[k]++;
          if (mcnt[k] == mw[k]) begin
            mout[k]   = bundle(k, din[k]);
            mvalid[k] = 1;
            mcnt[k]   = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int k, input logic [0:DIM-1] v);
    vin[k] = 1'b1;
    din[k] = v;
    step();
    vin[k] = 1'b0;
  endtask

  logic [0:DIM-1] tie_exp;

  initial begin
`ifdef BUNDLE_TIEBREAK_LAST_EN
    tie_exp = ONES;
`else
    tie_exp = ZEROS;
`endif
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; rin[k] = 1'b0; din[k] = '0;
    end
    step();
    cmp_en = 1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_reset_ready[%0d]", k), 64'(rout[k]), 64'd1);
      chk($sformatf("post_reset_valid[%0d]", k), 64'(vout[k]), 64'd0);
      chk($sformatf("post_reset_hv[%0d]", k), 64'(hout[k]), 64'd0);
    end

    // WINDOW=3: ones, zeros, ones back to back -> all ones, 1-cycle latency.
    rin[0] = 1'b1;
    feed(0, ONES); feed(0, ZEROS); feed(0, ONES);
    chk("w3_valid_latency", 64'(vout[0]), 64'd1);
    chk("w3_hv_ones", 64'(hout[0]), 64'(ONES));
    step();
    chk("w3_ready_after", 64'(rout[0]), 64'd1);
    chk("w3_valid_drop", 64'(vout[0]), 64'd0);

    // WINDOW=4: zeros, zeros, ones, ones -> every bit ties.
    rin[1] = 1'b1;
    feed(1, ZEROS); feed(1, ZEROS); feed(1, ONES); feed(1, ONES);
    chk("w4_valid", 64'(vout[1]), 64'd1);
    chk("w4_tie_hv", 64'(hout[1]), 64'(tie_exp));
    step();

    // WINDOW=5: hold output with back-pressure while junk inputs are offered.
    rin[2] = 1'b0;
    feed(2, 16'hFFFF); feed(2, 16'hFF00); feed(2, 16'hF0F0);
    feed(2, 16'h0000); feed(2, 16'h0000);
    chk("w5_valid", 64'(vout[2]), 64'd1);
    chk("w5_hv", 64'(hout[2]), 64'h000000000000F000);
    for (int i = 0; i < 10; i++) begin
      vin[2] = 1'b1;
      din[2] = DIM'($urandom);
      step();
      chk("w5_hold_valid", 64'(vout[2]), 64'd1);
      chk("w5_hold_ready", 64'(rout[2]), 64'd0);
      chk("w5_hold_hv", 64'(hout[2]), 64'h000000000000F000);
    end
    vin[2] = 1'b0;
    rin[2] = 1'b1;
    step();
    chk("w5_release_ready", 64'(rout[2]), 64'd1);
    rin[2] = 1'b0;
    for (int i = 0; i < 5; i++) feed(2, 16'h0F0F);
    chk("w5_next_window_hv", 64'(hout[2]), 64'h0000000000000F0F);
    rin[2] = 1'b1;
    step();

    // WINDOW=3: partial window discarded by reset.
    rin[0] = 1'b1;
    feed(0, ONES); feed(0, ONES);
    rst = 1'b1;
    step();
    chk("rst_during_valid", 64'(vout[0]), 64'd0);
    chk("rst_during_hv", 64'(hout[0]), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_after_valid", 64'(vout[0]), 64'd0);
    chk("rst_after_hv", 64'(hout[0]), 64'd0);
    chk("rst_after_ready", 64'(rout[0]), 64'd1);
    feed(0, ZEROS); feed(0, ZEROS); feed(0, ZEROS);
    chk("rst_window_valid", 64'(vout[0]), 64'd1);
    chk("rst_window_hv", 64'(hout[0]), 64'd0);
    step();

    // WINDOW=3: A, C, F patterns with 2-cycle gaps -> per-bit majority E.
    feed(0, 16'hAAAA);
    step(); step();
    chk("gap_valid_low", 64'(vout[0]), 64'd0);
    feed(0, 16'hCCCC);
    step(); step();
    feed(0, 16'hFFFF);
    chk("gap_valid", 64'(vout[0]), 64'd1);
    chk("gap_hv_e", 64'(hout[0]), 64'h000000000000EEEE);
    step();

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
